// File: rtl/nzcv_flag_unit_pkg.sv
// Shared types for the NZCV flag unit: op_class codes, flag bit positions, packed flag set.
package nzcv_pkg;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_LOGIC = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Field order puts n at bit 3 and v at bit 0, matching msr_data {N,Z,C,V}.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/nzcv_flag_unit_if.sv
// Execute-stage to flag-unit bus: ALU result, MSR, exception events and registered flag outputs.
interface nzcv_flag_unit_if #(
    parameter int DATA_W = 32
);
    logic              upd_valid;
    logic [1:0]        op_class;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] result;
    logic              carry_out;
    logic              shift_carry_valid;
    logic              shift_carry;
    logic              msr_valid;
    logic [3:0]        msr_data;
    logic              exc_entry;
    logic              exc_return;
    logic              n_flag;
    logic              z_flag;
    logic              c_flag;
    logic              v_flag;
    logic              flags_updated;
    logic              stack_overflow;
    logic              stack_underflow;

    modport master (
        output upd_valid, op_class, operand_a, operand_b, result, carry_out,
               shift_carry_valid, shift_carry, msr_valid, msr_data, exc_entry, exc_return,
        input  n_flag, z_flag, c_flag, v_flag, flags_updated, stack_overflow, stack_underflow
    );

    modport slave (
        input  upd_valid, op_class, operand_a, operand_b, result, carry_out,
               shift_carry_valid, shift_carry, msr_valid, msr_data, exc_entry, exc_return,
        output n_flag, z_flag, c_flag, v_flag, flags_updated, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/nzcv_flag_unit_flag_stack.sv
// LIFO of saved flag sets for exception entry/return; entry 0 is always the top of stack.
module flag_stack
    import nzcv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  nzcv_t push_data,
    output nzcv_t top,
    output logic  full,
    output logic  empty
);
    localparam int CW = $clog2(DEPTH + 1);

    nzcv_t         mem [DEPTH];
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push) begin
            count <= count + CW'(1);
        end else if (pop) begin
            count <= count - CW'(1);
        end
    end

    // Shift-register storage keeps the top at a fixed slot, so no read pointer is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
    end

    assign top   = mem[0];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/nzcv_flag_unit.sv
// Architectural NZCV flag register with MSR write and optional exception save/restore stack.
// The stack is built only when NZCV_FLAG_STACK_EN is defined; otherwise exc_* are ignored.
module nzcv_flag_unit
    import nzcv_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    nzcv_flag_unit_if.slave   bus
);
    nzcv_t flags_q, flags_d, alu_flags;
    logic  flags_updated_q, pulse_d;
    logic  entry_act, return_act;
    logic  stk_push, stk_pop, stk_full, stk_empty;
    logic  ovf_set, unf_set;
    nzcv_t stk_top;
    logic  a_msb, b_msb, r_msb;

    assign a_msb = bus.operand_a[DATA_W-1];
    assign b_msb = bus.operand_b[DATA_W-1];
    assign r_msb = bus.result[DATA_W-1];

    always_comb begin
        alu_flags   = flags_q;
        alu_flags.n = r_msb;
        alu_flags.z = (bus.result == '0);
        case (bus.op_class)
            OP_ADD: begin
                alu_flags.c = bus.carry_out;
                alu_flags.v = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                alu_flags.c = bus.carry_out;
                alu_flags.v = (a_msb != b_msb) && (r_msb != a_msb);
            end
            default: begin
                if (bus.shift_carry_valid) alu_flags.c = bus.shift_carry;
            end
        endcase
    end

`ifdef NZCV_FLAG_STACK_EN
    logic ovf_q, unf_q;

    assign entry_act  = bus.exc_entry;
    assign return_act = !bus.exc_entry && bus.exc_return;

    flag_stack #(.DEPTH(STACK_DEPTH)) u_flag_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (flags_q),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
`else
    localparam int unused_depth = STACK_DEPTH;
    logic unused_stack;

    assign entry_act  = 1'b0;
    assign return_act = 1'b0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign stk_top    = '0;
    assign unused_stack = ^{stk_push, stk_pop, ovf_set, unf_set, bus.exc_entry, bus.exc_return};

    assign bus.stack_overflow  = 1'b0;
    assign bus.stack_underflow = 1'b0;
`endif

    // Priority: exc_entry > exc_return > msr_valid > upd_valid; only the winner acts.
    always_comb begin
        flags_d  = flags_q;
        pulse_d  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (entry_act) begin
            if (stk_full) ovf_set  = 1'b1;
            else          stk_push = 1'b1;
        end else if (return_act) begin
            if (stk_empty) begin
                unf_set = 1'b1;
            end else begin
                stk_pop = 1'b1;
                flags_d = stk_top;
                pulse_d = 1'b1;
            end
        end else if (bus.msr_valid) begin
            flags_d = nzcv_t'(bus.msr_data);
            pulse_d = 1'b1;
        end else if (bus.upd_valid) begin
            flags_d = alu_flags;
            pulse_d = (alu_flags != flags_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q         <= '0;
            flags_updated_q <= 1'b0;
        end else begin
            flags_q         <= flags_d;
            flags_updated_q <= pulse_d;
        end
    end

    assign bus.n_flag        = flags_q[FLAG_N];
    assign bus.z_flag        = flags_q[FLAG_Z];
    assign bus.c_flag        = flags_q[FLAG_C];
    assign bus.v_flag        = flags_q[FLAG_V];
    assign bus.flags_updated = flags_updated_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Randomized and directed bench for nzcv_flag_unit against a queue-based reference model.
module tb_nzcv_flag_unit;
    import nzcv_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef NZCV_FLAG_STACK_EN
    localparam bit STACK_ON = 1'b1;
`else
    localparam bit STACK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nzcv_flag_unit_if #(.DATA_W(DATA_W)) bus ();

    nzcv_flag_unit #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    bit [3:0] m_flags;
    bit       m_upd, m_ovf, m_unf;
    bit [3:0] m_stack [$];

    task automatic idle();
        bus.upd_valid         = 1'b0;
        bus.op_class          = OP_ADD;
        bus.operand_a         = '0;
        bus.operand_b         = '0;
        bus.result            = '0;
        bus.carry_out         = 1'b0;
        bus.shift_carry_valid = 1'b0;
        bus.shift_carry       = 1'b0;
        bus.msr_valid         = 1'b0;
        bus.msr_data          = 4'h0;
        bus.exc_entry         = 1'b0;
        bus.exc_return        = 1'b0;
    endtask

    // Presents a self-consistent ALU result for the chosen operation.
    task automatic set_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_class  = op;
        bus.operand_a = a;
        bus.operand_b = b;
        case (op)
            2'd0: begin
                bus.result    = a + b;
                bus.carry_out = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
            end
            2'd1: begin
                bus.result    = a - b;
                bus.carry_out = (a >= b);
            end
            default: begin
                bus.result    = ($urandom_range(0, 3) == 0) ? 32'h0 : (a & b);
                bus.carry_out = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic model_step();
        bit [3:0] old;
        longint   s;
        bit       n, z, c, v;
        old   = m_flags;
        m_upd = 1'b0;
        if (rst) begin
            m_flags = 4'h0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_stack.delete();
        end else if (STACK_ON && bus.exc_entry) begin
            if (m_stack.size() == DEPTH) m_ovf = 1'b1;
            else m_stack.push_front(m_flags);
        end else if (STACK_ON && bus.exc_return) begin
            if (m_stack.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_flags = m_stack.pop_front();
                m_upd   = 1'b1;
            end
        end else if (bus.msr_valid) begin
            m_flags = bus.msr_data;
            m_upd   = 1'b1;
        end else if (bus.upd_valid) begin
            n = bus.result[31];
            z = (bus.result == 32'h0);
            c = old[1];
            v = old[0];
            if (bus.op_class == 2'd0) begin
                s = longint'($signed(bus.operand_a)) + longint'($signed(bus.operand_b));
                c = bus.carry_out;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (bus.op_class == 2'd1) begin
                s = longint'($signed(bus.operand_a)) - longint'($signed(bus.operand_b));
                c = bus.carry_out;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (bus.shift_carry_valid) begin
                c = bus.shift_carry;
            end
            m_flags = {n, z, c, v};
            m_upd   = (m_flags != old);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs_vec();
        return {bus.n_flag, bus.z_flag, bus.c_flag, bus.v_flag,
                bus.flags_updated, bus.stack_overflow, bus.stack_underflow};
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_flags, m_upd, m_ovf, m_unf};
    endfunction

    task automatic test_reset();
        logic [6:0] obs;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        obs = obs_vec();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset nzcv/upd/ovf/unf got=%b want=%b", obs, 7'b0);
        end
    endtask

    task automatic test_add_overflow();
        logic [6:0] obs;
        idle();
        bus.upd_valid = 1'b1;
        set_alu(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b1001_1_00) begin
            bad++;
            $display("FAIL add_overflow got=%b want=%b", obs, 7'b1001_1_00);
        end
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL add_overflow_model got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_sub_logic();
        logic [6:0] obs;
        idle();
        bus.upd_valid = 1'b1;
        set_alu(OP_SUB, 32'd5, 32'd5);
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b0110_1_00) begin
            bad++;
            $display("FAIL sub_equal got=%b want=%b", obs, 7'b0110_1_00);
        end
        idle();
        bus.upd_valid = 1'b1;
        bus.op_class  = OP_LOGIC;
        bus.result    = 32'h1;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b0010_1_00) begin
            bad++;
            $display("FAIL logic_keep_cv got=%b want=%b", obs, 7'b0010_1_00);
        end
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b0010_0_00) begin
            bad++;
            $display("FAIL logic_no_change_pulse got=%b want=%b", obs, 7'b0010_0_00);
        end
        idle();
        tick();
        obs = obs_vec();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL idle_hold got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_msr_priority();
        logic [6:0] obs;
        idle();
        bus.upd_valid = 1'b1;
        set_alu(OP_ADD, 32'h0, 32'h0);
        bus.msr_valid = 1'b1;
        bus.msr_data  = 4'b1010;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b1010_1_00) begin
            bad++;
            $display("FAIL msr_over_upd got=%b want=%b", obs, 7'b1010_1_00);
        end
    endtask

`ifdef NZCV_FLAG_STACK_EN
    task automatic test_stack();
        logic [6:0] obs;
        logic [3:0] sets [4];
        sets[0] = 4'h1; sets[1] = 4'h6; sets[2] = 4'h9; sets[3] = 4'hE;
        for (int k = 0; k < 4; k++) begin
            idle();
            bus.msr_valid = 1'b1;
            bus.msr_data  = sets[k];
            tick();
            idle();
            bus.exc_entry = 1'b1;
            bus.msr_valid = 1'b1;
            bus.msr_data  = 4'h0;
            tick();
            obs = obs_vec();
            total++;
            if (obs !== {sets[k], 3'b000}) begin
                bad++;
                $display("FAIL push_%0d got=%b want=%b", k, obs, {sets[k], 3'b000});
            end
        end
        idle();
        bus.msr_valid = 1'b1;
        bus.msr_data  = 4'h0;
        tick();
        idle();
        bus.exc_entry = 1'b1;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b0000_0_10) begin
            bad++;
            $display("FAIL push_overflow got=%b want=%b", obs, 7'b0000_0_10);
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            bus.exc_return = 1'b1;
            tick();
            obs = obs_vec();
            total++;
            if (obs !== {sets[3-k], 3'b110}) begin
                bad++;
                $display("FAIL pop_%0d got=%b want=%b", k, obs, {sets[3-k], 3'b110});
            end
        end
        idle();
        bus.exc_return = 1'b1;
        bus.msr_valid  = 1'b1;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b0001_0_11) begin
            bad++;
            $display("FAIL pop_underflow got=%b want=%b", obs, 7'b0001_0_11);
        end
        idle();
        bus.msr_valid = 1'b1;
        bus.msr_data  = 4'b0101;
        tick();
        idle();
        bus.exc_entry = 1'b1;
        tick();
        idle();
        bus.exc_return = 1'b1;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL push_then_pop got=%b want=%b", obs, exp_vec());
        end
    endtask
`else
    task automatic test_stack();
        logic [6:0] obs;
        idle();
        bus.exc_entry = 1'b1;
        bus.upd_valid = 1'b1;
        set_alu(OP_ADD, 32'h0, 32'h0);
        tick();
        obs = obs_vec();
        total++;
        if (obs[5] !== 1'b1 || obs[1:0] !== 2'b00 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL nostack_entry_ignored got=%b want=%b", obs, exp_vec());
        end
        idle();
        bus.exc_return = 1'b1;
        bus.msr_valid  = 1'b1;
        bus.msr_data   = 4'b0011;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== 7'b0011_1_00) begin
            bad++;
            $display("FAIL nostack_return_ignored got=%b want=%b", obs, 7'b0011_1_00);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [6:0] obs;
        idle();
        bus.msr_valid = 1'b1;
        bus.msr_data  = 4'b1111;
        tick();
        idle();
        rst           = 1'b1;
        bus.exc_entry = 1'b1;
        tick();
        rst = 1'b0;
        obs = obs_vec();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset_mid got=%b want=%b", obs, 7'b0);
        end
        idle();
        bus.exc_return = 1'b1;
        tick();
        obs = obs_vec();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL pop_after_reset got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [6:0]  obs;
        logic [31:0] a, b;
        for (int i = 0; i < 600; i++) begin
            idle();
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            set_alu(2'($urandom_range(0, 3)), a, b);
            bus.upd_valid         = ($urandom_range(0, 3) != 0);
            bus.shift_carry_valid = 1'($urandom_range(0, 1));
            bus.shift_carry       = 1'($urandom_range(0, 1));
            bus.msr_valid         = ($urandom_range(0, 7) == 0);
            bus.msr_data          = 4'($urandom_range(0, 15));
            bus.exc_entry         = ($urandom_range(0, 5) == 0);
            bus.exc_return        = ($urandom_range(0, 5) == 0);
            rst                   = ($urandom_range(0, 79) == 0);
            tick();
            rst = 1'b0;
            obs = obs_vec();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_add_overflow();
        test_sub_logic();
        test_msr_priority();
        test_stack();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nzcv_flag_unit.md
# nzcv_flag_unit

Architectural flag register (N, Z, C, V) that produces the flag inputs consumed by the condition checker. It computes new flags from ALU and shifter results and holds them between instructions. It also supports a direct flag write (MSR), and saves/restores flags across exception entry and return. It sits between the execute-stage ALU and the branch/conditional-execute logic.

## Interface
- `DATA_W`, default 32, ALU datapath width; MSB is bit `DATA_W-1`.
- `STACK_DEPTH`, default 4, number of saved flag sets; minimum 1.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `upd_valid`  in  1  ALU result present; update flags this cycle.
- `op_class`  in  2  encoding:
  - 0 ADD
  - 1 SUB/CMP
  - 2 LOGICAL
  - 3 reserved (treated as LOGICAL)
- `operand_a`, `operand_b`  in  DATA_W  ALU operands as presented to the adder. For SUB, `operand_b` is the un-inverted subtrahend.
- `result`  in  DATA_W  ALU result.
- `carry_out`  in  1  adder carry-out. For SUB this is NOT-borrow (ARM convention).
- `shift_carry_valid`  in  1  shifter produced a carry for a LOGICAL op.
- `shift_carry`  in  1  shifter carry-out.
- `msr_valid`  in  1  direct flag write.
- `msr_data`  in  4  {N,Z,C,V}.
- `exc_entry`  in  1  push current flags.
- `exc_return`  in  1  pop saved flags.
- `n_flag`, `z_flag`, `c_flag`, `v_flag`  out  1 each  registered flags.
- `flags_updated`  out  1  one-cycle pulse; asserted the cycle after any flag change.
- `stack_overflow`, `stack_underflow`  out  1  sticky error bits.

## Operation
- Event priority when several events occur in one cycle: `exc_entry` > `exc_return` > `msr_valid` > `upd_valid`. Only the highest-priority event acts; lower ones are dropped.
- Flag computation for `upd_valid`:
  - N = `result[DATA_W-1]`.
  - Z = (`result` == 0).
  - ADD: C = `carry_out`. V = (a.msb == b.msb) && (r.msb != a.msb).
  - SUB: C = `carry_out`. V = (a.msb != b.msb) && (r.msb != a.msb).
  - LOGICAL: C = `shift_carry` if `shift_carry_valid`, else C is unchanged. V is unchanged.
- `msr_valid`: {N,Z,C,V} <= `msr_data`.
- `exc_entry`:
  - Pushes the current {N,Z,C,V}; the flags themselves are unchanged.
  - If the stack is full: no push, `stack_overflow` is set, and the top entry is preserved.
- `exc_return`:
  - Pops and loads the flags.
  - If the stack is empty: flags unchanged and `stack_underflow` is set.
- `flags_updated` asserts only if the new value differs from the old value, or if an `msr_valid`/pop occurred.
- Reset values:
  - All flags 0.
  - Stack pointer 0 (empty).
  - `flags_updated`, `stack_overflow`, `stack_underflow` all 0.
  - Sticky error bits clear only on `rst`.

## Timing
- All outputs are registered.
- An event in cycle T is visible on the flag outputs in cycle T+1, so a conditional instruction issued in T+1 sees the new flags.
- `flags_updated` is high for exactly cycle T+1.
- Back-to-back updates every cycle are supported with no bubbles.
- Push and pop in consecutive cycles are legal; the pop returns the just-pushed value.
- Reset mid-operation: `rst` in cycle T overrides every event in T. Outputs hold their reset values in T+1, and stack contents are discarded.

## Configuration
- `NZCV_FLAG_STACK_EN` defined:
  - Save/restore stack is present as described.
- `NZCV_FLAG_STACK_EN` undefined:
  - No storage is instantiated.
  - `exc_entry` and `exc_return` are ignored and do not block lower-priority events.
  - `stack_overflow` and `stack_underflow` are tied to 0.

## Structure
- Shared package `nzcv_pkg` holds:
  - op_class localparams `OP_ADD`, `OP_SUB`, `OP_LOGIC`.
  - Flag bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - A packed 4-bit flags typedef.
- One sub-module, `flag_stack`: a `STACK_DEPTH`×4 LIFO with push, pop, full, empty and top. It is instantiated only under the macro.
- Combinational flag compute and priority arbitration live in the top module.

## Test plan
- ADD, `DATA_W`=32: a=0x7FFFFFFF, b=1, result=0x80000000, carry_out=0 → next cycle N=1, Z=0, C=0, V=1, `flags_updated`=1.
- SUB: a=5, b=5, result=0, carry_out=1 → N=0, Z=1, C=1, V=0. Then LOGICAL with result=0x1 and `shift_carry_valid`=0 → Z=0, C stays 1, V stays 0.
- `msr_valid` with `msr_data`=4'b1010 and `upd_valid` asserted in the same cycle → flags = {N=1, Z=0, C=1, V=0}; the ALU update is ignored.
- Push 4 distinct flag sets (`STACK_DEPTH`=4), then a 5th `exc_entry` → `stack_overflow`=1. Four pops then return the sets in reverse order. A 5th pop → `stack_underflow`=1 and flags unchanged.
- Set flags to 4'b1111, then assert `rst` in the same cycle as `exc_entry` → next cycle all flags 0, stack empty, and a following pop sets `stack_underflow`.
- Build without `NZCV_FLAG_STACK_EN`: `exc_entry` together with `upd_valid` (result=0) → Z=1 and both error outputs stay 0.
